// File: rtl/phase_pwm_driver.sv
// phase_pwm_driver: PWM carrier plus three dead-time-protected half-bridge gate FSMs.
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   enable                0 forces every switch off
//   duty                  high-side on-time in clocks per carrier period, latched at carrier 0
//   u / z                 commutation drive / float masks, bit2 = phase A .. bit0 = phase C
//   gate_high / gate_low  registered gate enables per phase, 1 = on
//   period_start          one-clock pulse while the carrier is 0
module phase_pwm_driver #(
  parameter int PWM_WIDTH = 10,
  parameter int DEAD_TIME = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [PWM_WIDTH-1:0] duty,
  input  logic [2:0]           u,
  input  logic [2:0]           z,
  output logic [2:0]           gate_high,
  output logic [2:0]           gate_low,
  output logic                 period_start
);
  typedef enum logic [1:0] {OFF, HI, LO, DEAD} state_t;
  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_TIME - 1);
  logic [PWM_WIDTH-1:0] carrier_q, carrier_d;
  logic [PWM_WIDTH-1:0] duty_lat_q, duty_lat_d;
  logic                 period_start_q, period_start_d;
  logic [2:0]           gate_high_q, gate_high_d;
  logic [2:0]           gate_low_q, gate_low_d;
  state_t               state_q [3];
  state_t               state_d [3];
  state_t               req [3];
  logic [7:0]           dead_cnt_q [3];
  logic [7:0]           dead_cnt_d [3];
  logic                 pwm_on;
  always_comb begin
    carrier_d      = carrier_q + PWM_WIDTH'(1);
    duty_lat_d     = (carrier_q == '0) ? duty : duty_lat_q;
    // registered so the pulse lines up with the cycle in which the carrier reads 0
    period_start_d = &carrier_q;
    pwm_on         = carrier_q < duty_lat_q;
    for (int i = 0; i < 3; i++) begin
      req[i]        = (!enable || z[i]) ? OFF : (u[i] && pwm_on) ? HI : LO;
      state_d[i]    = state_q[i];
      dead_cnt_d[i] = dead_cnt_q[i];
      unique case (state_q[i])
        OFF: state_d[i] = req[i];
        HI, LO: if (req[i] != state_q[i]) begin
          state_d[i]    = DEAD;
          dead_cnt_d[i] = DEAD_LOAD;
        end
        // the full dead time runs out even if the request flips back meanwhile
        DEAD: if (dead_cnt_q[i] != 8'd0) dead_cnt_d[i] = dead_cnt_q[i] - 8'd1;
              else state_d[i] = req[i];
        default: state_d[i] = OFF;
      endcase
      gate_high_d[i] = state_d[i] == HI;
      gate_low_d[i]  = state_d[i] == LO;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      carrier_q      <= '0;
      duty_lat_q     <= '0;
      period_start_q <= 1'b0;
      gate_high_q    <= '0;
      gate_low_q     <= '0;
      state_q        <= '{default: OFF};
      dead_cnt_q     <= '{default: 8'd0};
    end else begin
      carrier_q      <= carrier_d;
      duty_lat_q     <= duty_lat_d;
      period_start_q <= period_start_d;
      gate_high_q    <= gate_high_d;
      gate_low_q     <= gate_low_d;
      state_q        <= state_d;
      dead_cnt_q     <= dead_cnt_d;
    end
  end
  assign gate_high    = gate_high_q;
  assign gate_low     = gate_low_q;
  assign period_start = period_start_q;
endmodule

// File: tb/tb_phase_pwm_driver.sv
// tb_phase_pwm_driver: scoreboard bench for phase_pwm_driver with per-period gate statistics.
module tb_phase_pwm_driver;
  localparam int DT = 8;
  localparam int PER = 1024;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] duty = '0;
  logic [2:0] u = '0;
  logic [2:0] z = '0;
  logic [2:0] gate_high, gate_low;
  logic       period_start;
  int errors = 0;
  int checks = 0;
  int m_car, m_dl;
  int m_st [3];
  int m_cnt [3];
  int n_ah, n_al, n_b, n_cl, n_ps;
  logic [6:0] sb [$];
  phase_pwm_driver #(.PWM_WIDTH(10), .DEAD_TIME(DT)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .duty(duty), .u(u), .z(z),
    .gate_high(gate_high), .gate_low(gate_low), .period_start(period_start)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask
  task automatic model_reset();
    m_car = 0;
    m_dl  = 0;
    for (int i = 0; i < 3; i++) begin
      m_st[i]  = 0;
      m_cnt[i] = 0;
    end
    sb.delete();
  endtask
  task automatic clr();
    n_ah = 0; n_al = 0; n_b = 0; n_cl = 0; n_ps = 0;
  endtask
  // states: 0 off, 1 high, 2 low, 3 dead
  task automatic step();
    logic [2:0] egh, egl;
    logic [6:0] want;
    bit pwm;
    int req;
    pwm = m_car < m_dl;
    for (int i = 0; i < 3; i++) begin
      req = (!enable || z[i]) ? 0 : (u[i] && pwm) ? 1 : 2;
      if (m_st[i] == 3) begin
        if (m_cnt[i] > 0) m_cnt[i]--;
        else m_st[i] = req;
      end else if (m_st[i] == 0) m_st[i] = req;
      else if (m_st[i] != req) begin
        m_st[i]  = 3;
        m_cnt[i] = DT - 1;
      end
      egh[i] = m_st[i] == 1;
      egl[i] = m_st[i] == 2;
    end
    sb.push_back({m_car == PER - 1, egh, egl});
    if (m_car == 0) m_dl = duty;
    m_car = (m_car + 1) % PER;
    @(posedge clock);
    #1;
    want = sb.pop_front();
    check("gates", {period_start, gate_high, gate_low}, want);
    check("overlap", gate_high & gate_low, 0);
    n_ah += gate_high[2];
    n_al += gate_low[2];
    n_b  += gate_high[1] | gate_low[1];
    n_cl += gate_low[0];
    n_ps += period_start;
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  task automatic align();
    while (m_car != 0) step();
  endtask
  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("rst_gates", {gate_high, gate_low}, 0);
    check("rst_ps", period_start, 0);
    reset_n = 1'b1;
    clr();
    run(2 * PER);
    check("t1_ps_count", n_ps, 2);
    check("t1_idle", n_ah + n_al, 0);
    enable = 1'b1; u = 3'b100; z = 3'b010; duty = 10'd256;
    run(2 * PER);
    align();
    clr();
    run(PER);
    check("t2_a_high", n_ah, 256 - DT);
    check("t2_a_low", n_al, PER - 256 - DT);
    check("t2_b_off", n_b, 0);
    check("t2_c_low", n_cl, PER);
    check("t2_ps", n_ps, 1);
    clr();
    run(100);
    duty = 10'd512;
    run(PER - 100);
    check("t3_keep", n_ah, 256 - DT);
    clr();
    run(PER);
    check("t3_new", n_ah, 512 - DT);
    run(50);
    u = 3'b010; z = 3'b100;
    clr();
    step();
    check("t4_a_drop", gate_high[2], 0);
    run(900);
    check("t4_a_off", n_ah + n_al, 0);
    u = 3'b100; z = 3'b010; duty = 10'd0;
    run(2 * PER);
    align();
    clr();
    run(PER);
    check("t5_d0_high", n_ah, 0);
    check("t5_d0_low", n_al, PER);
    duty = 10'd1023;
    run(2 * PER);
    align();
    clr();
    run(PER);
    check("t5_dmax_high", n_ah, PER - DT);
    check("t5_dmax_low", n_al, 0);
    duty = 10'd512;
    run(2 * PER);
    align();
    run(100);
    check("t6_pre", {gate_high[2], gate_low[0]}, 2'b11);
    enable = 1'b0;
    step();
    check("t6_off", {gate_high, gate_low}, 0);
    run(20);
    enable = 1'b1;
    run(2 * PER);
    for (int r = 0; r < 40; r++) begin
      {u, z} = 6'($urandom);
      duty = 10'($urandom);
      enable = ($urandom_range(0, 7) != 0);
      run($urandom_range(3, 40));
    end
    u = 3'b100; z = 3'b010; enable = 1'b1; duty = 10'd300;
    run(PER + 50);
    reset_n = 1'b0;
    #2;
    check("async_gates", {gate_high, gate_low}, 0);
    check("async_ps", period_start, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    clr();
    run(PER + 50);
    check("rel_ps_count", n_ps, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
